// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle control unit for a MIPS-subset CPU. A Moore FSM walks each instruction through
// fetch, decode, execute, memory and writeback. It drives every datapath enable and mux
// select, and bounds the wait on the data RAM handshake.
//
// Ports:
//   clk, rst         clock, asynchronous active-low reset
//   Inst_code        current IR contents (opcode [31:26], funct [5:0])
//   Zero             ALU zero flag, used in the BEQ state
//   mem_ready        data RAM finished the access this cycle
//   PC_Write, PC_s   PC load enable and source select (00 +4, 01 branch, 10 jump)
//   IR_Write         IR load enable
//   Reg_Write        register file write enable
//   w_r_s            write register select (0 rd, 1 rt)
//   wr_data_s        write data select (0 ALU, 1 memory)
//   rt_imm_s, imm_s  ALU B select and immediate sign-extension
//   ALU_OP           ALU operation
//   Mem_Req          data RAM request
//   Mem_Write        1 store, 0 load
//   err              sticky fault (illegal opcode/funct or memory timeout)
//   state            current state, for debug
module multi_cycle_ctrl #(
  parameter int unsigned MEM_WAIT_MAX = 15,
  parameter int unsigned CNT_W        = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Inst_code,
  input  logic        Zero,
  input  logic        mem_ready,
  output logic        PC_Write,
  output logic [1:0]  PC_s,
  output logic        IR_Write,
  output logic        Reg_Write,
  output logic        w_r_s,
  output logic        wr_data_s,
  output logic        rt_imm_s,
  output logic        imm_s,
  output logic [2:0]  ALU_OP,
  output logic        Mem_Req,
  output logic        Mem_Write,
  output logic        err,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    StIdle    = 4'd0,
    StIf      = 4'd1,
    StId      = 4'd2,
    StExR     = 4'd3,
    StWbR     = 4'd4,
    StExI     = 4'd5,
    StWbI     = 4'd6,
    StMemAddr = 4'd7,
    StMemRd   = 4'd8,
    StWbLw    = 4'd9,
    StMemWr   = 4'd10,
    StBeq     = 4'd11,
    StJ       = 4'd12,
    StErr     = 4'd15
  } state_e;

  localparam logic [2:0] AluAnd  = 3'b000;
  localparam logic [2:0] AluOr   = 3'b001;
  localparam logic [2:0] AluXor  = 3'b010;
  localparam logic [2:0] AluNor  = 3'b011;
  localparam logic [2:0] AluAdd  = 3'b100;
  localparam logic [2:0] AluSub  = 3'b101;
  localparam logic [2:0] AluSltu = 3'b110;
  localparam logic [2:0] AluSll  = 3'b111;

  localparam logic [CNT_W-1:0] WaitLast = CNT_W'(MEM_WAIT_MAX - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [5:0] opcode, funct;
  logic [2:0] r_alu, i_alu;
  logic       r_ok, i_imm;
  logic       unused_inst;

  assign opcode      = Inst_code[31:26];
  assign funct       = Inst_code[5:0];
  assign unused_inst = ^Inst_code[25:6];

  // R-type funct decode; r_ok low sends EX_R to the error state.
  always_comb begin
    r_ok  = 1'b1;
    r_alu = AluAnd;
    case (funct)
      6'b100000: r_alu = AluAdd;
      6'b100010: r_alu = AluSub;
      6'b100100: r_alu = AluAnd;
      6'b100101: r_alu = AluOr;
      6'b100110: r_alu = AluXor;
      6'b100111: r_alu = AluNor;
      6'b101011: r_alu = AluSltu;
      6'b000000: r_alu = AluSll;
      default:   r_ok  = 1'b0;
    endcase
  end

  // I-type opcode decode: ALU op and immediate extension.
  always_comb begin
    i_alu = AluAnd;
    i_imm = 1'b0;
    case (opcode)
      6'b001000: begin i_alu = AluAdd;  i_imm = 1'b1; end
      6'b001100: begin i_alu = AluAnd;  i_imm = 1'b0; end
      6'b001101: begin i_alu = AluOr;   i_imm = 1'b0; end
      6'b001110: begin i_alu = AluXor;  i_imm = 1'b0; end
      6'b001011: begin i_alu = AluSltu; i_imm = 1'b1; end
      default:   begin i_alu = AluAnd;  i_imm = 1'b0; end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: state_d = StIf;
      StIf:   state_d = StId;
      StId: begin
        case (opcode)
          6'b000000:                                         state_d = StExR;
          6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001011: state_d = StExI;
          6'b100011, 6'b101011:                              state_d = StMemAddr;
          6'b000100:                                         state_d = StBeq;
          6'b000010:                                         state_d = StJ;
          default:                                           state_d = StErr;
        endcase
      end
      StExR:  state_d = r_ok ? StWbR : StErr;
      StWbR:  state_d = StIf;
      StExI:  state_d = StWbI;
      StWbI:  state_d = StIf;
      StMemAddr: begin
        cnt_d   = '0;
        state_d = (opcode == 6'b101011) ? StMemWr : StMemRd;
      end
      StMemRd, StMemWr: begin
        // mem_ready takes priority over the timeout on the last allowed cycle.
        if (mem_ready) begin
          state_d = (state_q == StMemRd) ? StWbLw : StIf;
        end else if (cnt_q == WaitLast) begin
          state_d = StErr;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWbLw: state_d = StIf;
      StBeq:  state_d = StIf;
      StJ:    state_d = StIf;
      StErr:  state_d = StErr;
      default: state_d = StErr;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode from the state register only (plus Inst_code/Zero), so an async reset
  // clears every enable at once.
  always_comb begin
    PC_Write  = 1'b0;
    PC_s      = 2'b00;
    IR_Write  = 1'b0;
    Reg_Write = 1'b0;
    w_r_s     = 1'b0;
    wr_data_s = 1'b0;
    rt_imm_s  = 1'b0;
    imm_s     = 1'b0;
    ALU_OP    = AluAnd;
    Mem_Req   = 1'b0;
    Mem_Write = 1'b0;
    err       = 1'b0;
    case (state_q)
      StIf: begin
        PC_Write = 1'b1;
        IR_Write = 1'b1;
      end
      StExR: ALU_OP = r_alu;
      StWbR: begin
        ALU_OP    = r_alu;
        Reg_Write = 1'b1;
      end
      StExI: begin
        ALU_OP   = i_alu;
        imm_s    = i_imm;
        rt_imm_s = 1'b1;
      end
      StWbI: begin
        ALU_OP    = i_alu;
        imm_s     = i_imm;
        rt_imm_s  = 1'b1;
        Reg_Write = 1'b1;
        w_r_s     = 1'b1;
      end
      StMemAddr, StMemRd, StMemWr: begin
        ALU_OP    = AluAdd;
        rt_imm_s  = 1'b1;
        imm_s     = 1'b1;
        Mem_Req   = (state_q != StMemAddr);
        Mem_Write = (state_q == StMemWr);
      end
      StWbLw: begin
        Reg_Write = 1'b1;
        w_r_s     = 1'b1;
        wr_data_s = 1'b1;
      end
      StBeq: begin
        ALU_OP   = AluSub;
        PC_s     = 2'b01;
        PC_Write = Zero;
      end
      StJ: begin
        PC_Write = 1'b1;
        PC_s     = 2'b10;
      end
      StErr: err = 1'b1;
      default: ;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
module tb_multi_cycle_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] Inst_code = 32'h0;
  logic        Zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        PC_Write, IR_Write, Reg_Write, w_r_s, wr_data_s, rt_imm_s, imm_s;
  logic        Mem_Req, Mem_Write, err;
  logic [1:0]  PC_s;
  logic [2:0]  ALU_OP;
  logic [3:0]  state;

  multi_cycle_ctrl #(.MEM_WAIT_MAX(15), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .Inst_code(Inst_code), .Zero(Zero), .mem_ready(mem_ready),
    .PC_Write(PC_Write), .PC_s(PC_s), .IR_Write(IR_Write), .Reg_Write(Reg_Write),
    .w_r_s(w_r_s), .wr_data_s(wr_data_s), .rt_imm_s(rt_imm_s), .imm_s(imm_s),
    .ALU_OP(ALU_OP), .Mem_Req(Mem_Req), .Mem_Write(Mem_Write), .err(err), .state(state)
  );

  always #5 clk = ~clk;

  // {PC_Write, PC_s, IR_Write, Reg_Write, w_r_s, wr_data_s, rt_imm_s, imm_s, ALU_OP,
  //  Mem_Req, Mem_Write, err, state}
  logic [18:0] obs;
  assign obs = {PC_Write, PC_s, IR_Write, Reg_Write, w_r_s, wr_data_s, rt_imm_s, imm_s,
                ALU_OP, Mem_Req, Mem_Write, err, state};

  typedef struct {
    logic [31:0] inst;
    logic        zero;
    int          rdy;   // sequence index where mem_ready is pulsed, -1 for never
    logic [2:0]  alu;   // ALU_OP expected in the execute/writeback states
    logic        imms;  // imm_s expected in EX_I/WB_I
    logic [95:0] seq;   // expected states, one nibble each, first state most significant
    int          len;
  } vec_t;

  localparam int NV = 19;
  vec_t        vecs[NV];
  logic [18:0] sb_q[$];
  int          tests = 0;
  int          fails = 0;

  function automatic logic [18:0] exp_out(input logic [3:0] st, input logic [2:0] alu,
                                          input logic ims_i, input logic zero);
    logic pcw, irw, regw, wrs, wds, rtis, ims, mreq, mwr, er;
    logic [1:0] pcs;
    logic [2:0] aop;
    {pcw, irw, regw, wrs, wds, rtis, ims, mreq, mwr, er} = '0;
    pcs = 2'b00;
    aop = 3'b000;
    case (st)
      4'd1:  begin pcw = 1'b1; irw = 1'b1; end
      4'd3:  aop = alu;
      4'd4:  begin aop = alu; regw = 1'b1; end
      4'd5:  begin aop = alu; rtis = 1'b1; ims = ims_i; end
      4'd6:  begin aop = alu; rtis = 1'b1; ims = ims_i; regw = 1'b1; wrs = 1'b1; end
      4'd7:  begin aop = 3'b100; rtis = 1'b1; ims = 1'b1; end
      4'd8:  begin aop = 3'b100; rtis = 1'b1; ims = 1'b1; mreq = 1'b1; end
      4'd10: begin aop = 3'b100; rtis = 1'b1; ims = 1'b1; mreq = 1'b1; mwr = 1'b1; end
      4'd9:  begin regw = 1'b1; wrs = 1'b1; wds = 1'b1; end
      4'd11: begin aop = 3'b101; pcs = 2'b01; pcw = zero; end
      4'd12: begin pcw = 1'b1; pcs = 2'b10; end
      4'd15: er = 1'b1;
      default: ;
    endcase
    return {pcw, pcs, irw, regw, wrs, wds, rtis, ims, aop, mreq, mwr, er, st};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Starts from a fresh reset and compares every cycle against the expected state list.
  task automatic run_vec(input int k);
    vec_t v;
    logic [3:0] st;
    logic [18:0] e;
    v = vecs[k];
    Inst_code = v.inst;
    Zero      = v.zero;
    mem_ready = 1'b0;
    rst       = 1'b0;
    #1;
    check($sformatf("v%0d reset", k), 32'(obs), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < v.len; i++) begin
      mem_ready = (i == v.rdy);
      st = v.seq[4*(v.len-1-i) +: 4];
      sb_q.push_back(exp_out(st, v.alu, v.imms, v.zero));
      #1;
      if (sb_q.size() == 0) begin
        check($sformatf("v%0d c%0d scoreboard empty", k, i), 32'd0, 32'd1);
      end else begin
        e = sb_q.pop_front();
        check($sformatf("v%0d c%0d outputs", k, i), 32'(obs), 32'(e));
      end
      @(negedge clk);
    end
    mem_ready = 1'b0;
  endtask

  initial begin
    int cnt;
    vecs[0]  = '{32'h00221820, 1'b0, -1, 3'b100, 1'b0, 96'h012341, 6};   // add
    vecs[1]  = '{32'h00221822, 1'b0, -1, 3'b101, 1'b0, 96'h012341, 6};   // sub
    vecs[2]  = '{32'h0022182B, 1'b0, -1, 3'b110, 1'b0, 96'h012341, 6};   // sltu
    vecs[3]  = '{32'h00221827, 1'b0, -1, 3'b011, 1'b0, 96'h012341, 6};   // nor
    vecs[4]  = '{32'h00000000, 1'b0, -1, 3'b111, 1'b0, 96'h012341, 6};   // sll
    vecs[5]  = '{32'h00221821, 1'b0, -1, 3'b000, 1'b0, 96'h0123FF, 6};   // bad funct
    vecs[6]  = '{32'h3422FFFF, 1'b0, -1, 3'b001, 1'b0, 96'h012561, 6};   // ori
    vecs[7]  = '{32'h2022FFFF, 1'b0, -1, 3'b100, 1'b1, 96'h012561, 6};   // addi
    vecs[8]  = '{32'h2C220001, 1'b0, -1, 3'b110, 1'b1, 96'h012561, 6};   // sltiu
    vecs[9]  = '{32'h38220001, 1'b0, -1, 3'b010, 1'b0, 96'h012561, 6};   // xori
    vecs[10] = '{32'h30220001, 1'b0, -1, 3'b000, 1'b0, 96'h012561, 6};   // andi
    vecs[11] = '{32'h8C220004, 1'b0, 6, 3'b000, 1'b0, 96'h012788891, 9}; // lw, 3 wait
    vecs[12] = '{32'hAC220004, 1'b0, 4, 3'b000, 1'b0, 96'h0127A1, 6};    // sw, ready at once
    vecs[13] = '{32'h10220003, 1'b1, -1, 3'b000, 1'b0, 96'h012B1, 5};    // beq taken
    vecs[14] = '{32'h10220003, 1'b0, -1, 3'b000, 1'b0, 96'h012B1, 5};    // beq not taken
    vecs[15] = '{32'h08000010, 1'b0, -1, 3'b000, 1'b0, 96'h012C1, 5};    // j
    vecs[16] = '{32'hFC000000, 1'b0, -1, 3'b000, 1'b0, 96'h012FFF, 6};   // illegal opcode
    // lw with mem_ready on the last allowed wait cycle: ready wins over timeout
    vecs[17] = '{32'h8C220004, 1'b0, 18, 3'b000, 1'b0,
                 96'({4'h0, 4'h1, 4'h2, 4'h7, {15{4'h8}}, 4'h9, 4'h1}), 21};
    // sw timeout: 15 cycles in MEM_WR, then ERR
    vecs[18] = '{32'hAC220004, 1'b0, -1, 3'b000, 1'b0,
                 96'({4'h0, 4'h1, 4'h2, 4'h7, {15{4'hA}}, 4'hF, 4'hF}), 21};

    @(negedge clk);
    for (int k = 0; k < NV; k++) run_vec(k);

    // sw timeout: count MEM_WR cycles, err is sticky, async reset clears it
    Inst_code = 32'hAC220004;
    mem_ready = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (state == 4'd10) cnt++;
      if (state == 4'd15) break;
    end
    check("timeout wait cycles", 32'(cnt), 32'd15);
    check("timeout state", 32'(state), 32'd15);
    repeat (4) @(negedge clk);
    check("err sticky", 32'({err, state}), 32'h1F);
    #2 rst = 1'b0;
    #1;
    check("err cleared by async reset", 32'({err, state}), 32'h0);
    @(negedge clk);
    check("held in reset", 32'(obs), 32'h0);

    // Reset asserted mid-load: outputs drop before any clock edge
    Inst_code = 32'h8C220004;
    rst = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (state == 4'd8) break;
    end
    check("reached MEM_RD", 32'({Mem_Req, state}), 32'h18);
    #2 rst = 1'b0;
    #1;
    check("async abort MEM_RD", 32'(obs), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("restart fetch", 32'(obs), 32'(exp_out(4'd1, 3'b000, 1'b0, 1'b0)));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multi_cycle_ctrl.md
Name: multi_cycle_ctrl

Overview:
- Multi-cycle control unit that sequences the instruction-fetch datapath: PC register, instruction ROM and IR.
- Also sequences the register file, ALU and data RAM of the CPU.
- Decodes the fetched MIPS-subset instruction and walks a Moore FSM through fetch/decode/execute/memory/writeback.
- Drives every datapath enable and mux select. Includes a bounded wait handshake with the data RAM.

Parameters:
- MEM_WAIT_MAX, 15, max cycles spent waiting for mem_ready before entering the error state.
- CNT_W, 4, width of the wait counter; must hold MEM_WAIT_MAX.

Ports:
- clk  in  1  system clock; state register updates on rising edge.
- rst  in  1  asynchronous, active-low reset (rst=0 resets).
- Inst_code  in  32  current IR contents; opcode [31:26], funct [5:0].
- Zero  in  1  ALU zero flag, valid in the BEQ state.
- mem_ready  in  1  data RAM completed access this cycle.
- PC_Write  out  1  PC load enable.
- PC_s  out  2  PC source select: 00 PC+4, 01 branch target, 10 jump target.
- IR_Write  out  1  IR load enable.
- Reg_Write  out  1  register file write enable.
- w_r_s  out  1  write-register select: 0 rd, 1 rt.
- wr_data_s  out  1  write-data select: 0 ALU result, 1 memory data.
- rt_imm_s  out  1  ALU B select: 0 rt, 1 extended immediate.
- imm_s  out  1  extension: 0 zero-extend, 1 sign-extend.
- ALU_OP  out  3  operation code.
- Mem_Req  out  1  RAM access request.
- Mem_Write  out  1  1 store, 0 load; valid while Mem_Req=1.
- err  out  1  sticky fault (illegal opcode or memory timeout).
- state  out  4  current state encoding, for debug.

Behaviour:
- Reset (rst=0, async): state=IDLE. All outputs 0, including PC_s=00, ALU_OP=000, err=0. Wait counter cleared.
- IDLE(0): unconditional -> IF on first clock after reset release.
- IF(1): PC_Write=1, IR_Write=1, PC_s=00 -> ID.
- ID(2): decode opcode and route:
  - 000000 -> EX_R
  - 001000/001100/001101/001110/001011 -> EX_I
  - 100011/101011 -> MEM_ADDR
  - 000100 -> BEQ
  - 000010 -> J
  - anything else -> ERR
- EX_R(3): ALU_OP from funct:
  - 100000 add=100, 100010 sub=101, 100100 and=000, 100101 or=001
  - 100110 xor=010, 100111 nor=011, 101011 sltu=110, 000000 sll=111
  - Unlisted funct -> ERR. Otherwise -> WB_R.
- WB_R(4): Reg_Write=1, w_r_s=0, wr_data_s=0. ALU_OP held from EX_R. -> IF.
- EX_I(5): rt_imm_s=1. ALU_OP/imm_s per opcode:
  - addi: ADD, imm_s=1
  - andi: AND, imm_s=0
  - ori: OR, imm_s=0
  - xori: XOR, imm_s=0
  - sltiu: SLTU, imm_s=1
  - -> WB_I.
- WB_I(6): Reg_Write=1, w_r_s=1, wr_data_s=0. EX_I selects held. -> IF.
- MEM_ADDR(7): ALU_OP=100, rt_imm_s=1, imm_s=1. Clear wait counter. lw -> MEM_RD, sw -> MEM_WR.
- MEM_RD(8) / MEM_WR(10): Mem_Req=1, Mem_Write=0/1. Address selects held.
  - mem_ready=1 -> WB_LW (load) or IF (store).
  - Otherwise counter += 1.
  - Counter reaches MEM_WAIT_MAX with mem_ready=0 -> ERR.
  - mem_ready=1 in the same cycle the limit is hit: mem_ready wins.
- WB_LW(9): Reg_Write=1, w_r_s=1, wr_data_s=1. -> IF.
- BEQ(11): ALU_OP=101, rt_imm_s=0, PC_s=01, PC_Write=Zero. -> IF.
- J(12): PC_Write=1, PC_s=10. -> IF.
- ERR(15): err=1, all enables 0. Remains until rst=0.
- Enables are asserted only in the states listed; 0 elsewhere. Outputs are a pure function of state and Inst_code/Zero (Moore plus Zero gating).
- CPI: R/I-type 4, lw 5+wait, sw 4+wait, beq 3, j 3.
- Reset asserted mid-instruction aborts immediately. No enable pulses after rst falls.

Test Plan:
- Reset release, Inst_code=0x00221820 (add $3,$1,$2) -> state 0,1,2,3,4,1. ALU_OP=100 in states 3-4. Reg_Write=1, w_r_s=0 only in state 4. PC_Write pulses once.
- Inst_code=0x8C220004 (lw), mem_ready raised 3 cycles into MEM_RD -> states 7,8,8,8,9,1. Mem_Req=1, Mem_Write=0 during 8. wr_data_s=1, Reg_Write=1 in 9.
- Inst_code=0xAC220004 (sw), mem_ready held 0 -> after 15 MEM_WR cycles state=15, err=1. Stays until rst=0, then state=0, err=0.
- Inst_code=0x10220003 (beq): Zero=1 -> PC_Write=1, PC_s=01 in state 11. Zero=0 -> PC_Write=0. Both return to IF.
- Inst_code=0x3422FFFF (ori) -> imm_s=0, rt_imm_s=1, ALU_OP=001, then WB_I with w_r_s=1. Inst_code=0xFC000000 -> ERR after ID.
- rst=0 asserted during MEM_RD -> state=0 and Mem_Req=0 immediately, without waiting for a clock edge.
